// File: rtl/cas_rec_pkg.sv
// Shared types and default timing for the cassette SAVE recorder.
package cas_rec_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CLK = 2'd1,
    CELL     = 2'd2,
    DATA     = 2'd3
  } state_t;

  localparam int DEF_CLK_HZ       = 42_000_000;
  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_SHORT_MAX_US = 1500;
  localparam int DEF_LONG_MAX_US  = 3000;
  localparam int DEF_GAP_US       = 10000;

  // Number of clk_sys cycles that make up one microsecond.
  function automatic int us_ticks(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  localparam int DEF_TICK_DIV = us_ticks(DEF_CLK_HZ);

endpackage

// File: rtl/cas_rec_ram.sv
// Simple dual-port byte buffer: the decoder writes, the upload path reads.
// Read-first, so a same-address read/write returns the previous contents.
module cas_rec_ram
  import cas_rec_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:(2**ADDR_W)-1];

  // Write port: store a committed byte.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered output that holds while no read is requested.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= 8'h00;
    end else if (i_rd) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/cas_recorder.sv
// Cassette SAVE recorder: decodes Level II 500-baud pulse trains from the
// cassette-output latch into bytes (MSB first), buffers them, and serves the
// buffer to the ioctl upload handshake.
module cas_recorder
  import cas_rec_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int SHORT_MAX_US = DEF_SHORT_MAX_US,
  parameter int LONG_MAX_US  = DEF_LONG_MAX_US,
  parameter int GAP_US       = DEF_GAP_US
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic [1:0]        i_cass_out,
  input  logic              i_rec_arm,
  input  logic              i_rec_stop,
  input  logic [ADDR_W-1:0] i_ul_addr,
  input  logic              i_ul_rd,
  output logic [7:0]        o_ul_data,
  output logic [ADDR_W:0]   o_rec_len,
  output logic              o_rec_active,
  output logic              o_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(GAP_US + 2);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]  r_pre;
  logic              w_tick;
  logic [1:0]        r_cass;
  logic [1:0]        r_cass_d;
  logic              w_edge;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_elapsed;
  logic              w_short;
  logic              w_long;
  logic              w_gap;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_cnt_clr;
  logic              w_bits_clr;
  logic              w_shift_en;
  logic              w_shift_bit;
  logic              w_len_clr;
  logic [6:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              w_commit;
  logic              w_wr_en;
  logic [7:0]        w_byte;
  logic [ADDR_W:0]   r_len;
  logic              r_ovf;
  logic              r_active;

  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

  // Prescaler producing a one-cycle tick every microsecond.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Register the latch value twice so a pulse start can be seen as a change to 01.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_cass   <= 2'b00;
      r_cass_d <= 2'b00;
    end else begin
      r_cass   <= i_cass_out;
      r_cass_d <= r_cass;
    end
  end

  assign w_edge = (r_cass == 2'b01) && (r_cass_d != 2'b01);

  // Elapsed time includes the current cycle's tick, so an edge D us after the
  // previous one is classified with interval exactly D.
  assign w_elapsed = r_cnt + CNT_W'(w_tick);
  assign w_short   = (w_elapsed <= CNT_W'(SHORT_MAX_US));
  assign w_long    = (w_elapsed <= CNT_W'(LONG_MAX_US));
  assign w_gap     = (w_elapsed >= CNT_W'(GAP_US));

  // Interval counter: microseconds since the last edge, saturating at the gap length.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_edge || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_tick && (r_cnt < CNT_W'(GAP_US))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Decoder state register.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath controls; stop beats arm, arm beats edge, edge beats gap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bits_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_shift_bit = 1'b0;
    w_len_clr   = 1'b0;
    if (i_rec_stop) begin
      w_state_nxt = IDLE;
      w_bits_clr  = 1'b1;
    end else if (i_rec_arm) begin
      w_state_nxt = WAIT_CLK;
      w_bits_clr  = 1'b1;
      w_len_clr   = 1'b1;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        WAIT_CLK: begin
          if (w_edge) begin
            w_state_nxt = CELL;
          end else begin
            w_state_nxt = WAIT_CLK;
          end
        end
        CELL: begin
          if (w_edge) begin
            if (w_short) begin
              w_shift_en  = 1'b1;
              w_shift_bit = 1'b1;
              w_state_nxt = DATA;
            end else if (w_long) begin
              w_shift_en  = 1'b1;
              w_state_nxt = CELL;
            end else begin
              w_bits_clr  = 1'b1;
              w_state_nxt = CELL;
            end
          end else if (w_gap) begin
            w_bits_clr  = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = WAIT_CLK;
          end else begin
            w_state_nxt = CELL;
          end
        end
        DATA: begin
          if (w_edge) begin
            if (w_short) begin
              w_state_nxt = CELL;
            end else begin
              w_bits_clr  = 1'b1;
              w_state_nxt = CELL;
            end
          end else if (w_gap) begin
            w_bits_clr  = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = WAIT_CLK;
          end else begin
            w_state_nxt = DATA;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Shift register and bit counter; the counter wraps to 0 after the 8th bit.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_shift   <= 7'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_bits_clr) begin
      r_shift   <= 7'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_shift_en) begin
      r_shift   <= {r_shift[5:0], w_shift_bit};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  assign w_commit = w_shift_en && (r_bit_cnt == 3'd7);
  assign w_byte   = {r_shift, w_shift_bit};
  assign w_wr_en  = w_commit && (r_len < (ADDR_W + 1)'(DEPTH));

  // Stored-length and sticky overflow bookkeeping.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_len_clr) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_wr_en) begin
      r_len <= r_len + (ADDR_W + 1)'(1);
    end else if (w_commit) begin
      r_ovf <= 1'b1;
    end
  end

  // Registered activity flag, tracking the state being entered.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= (w_state_nxt != IDLE);
    end
  end

  cas_rec_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk_sys),
    .i_rst   (i_reset),
    .i_we    (w_wr_en),
    .i_waddr (r_len[ADDR_W-1:0]),
    .i_wdata (w_byte),
    .i_rd    (i_ul_rd),
    .i_raddr (i_ul_addr),
    .o_rdata (o_ul_data)
  );

  assign o_rec_len    = r_len;
  assign o_rec_active = r_active;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_cas_recorder.sv
// Bench for cas_recorder: instance A uses the real timing constants,
// instance B a compressed timing with a 4-byte buffer for overflow and
// randomized pulse trains checked against a rule-level decoder model.
module tb_cas_recorder;
  import cas_rec_pkg::*;

  localparam int HA = 1000, FA = 2000;  // instance A half / full cell
  localparam int HB = 8,    FB = 22;    // instance B half / full cell
  localparam int SB = 15, LB = 30, GB = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, arm_a, arm_b, stop_a, stop_b, rd_a, rd_b;
  logic        act_a, act_b, ovf_a, ovf_b;
  logic [1:0]  cass_a, cass_b, addr_b;
  logic [13:0] addr_a;
  logic [7:0]  data_a, data_b;
  logic [14:0] len_a;
  logic [2:0]  len_b;

  int errors = 0;
  int checks = 0;

  cas_recorder #(.TICK_DIV(1), .ADDR_W(14)) dut_a (
    .i_clk_sys(clk), .i_reset(rst_a), .i_cass_out(cass_a), .i_rec_arm(arm_a),
    .i_rec_stop(stop_a), .i_ul_addr(addr_a), .i_ul_rd(rd_a), .o_ul_data(data_a),
    .o_rec_len(len_a), .o_rec_active(act_a), .o_overflow(ovf_a));

  cas_recorder #(.TICK_DIV(1), .ADDR_W(2), .SHORT_MAX_US(SB), .LONG_MAX_US(LB),
                 .GAP_US(GB)) dut_b (
    .i_clk_sys(clk), .i_reset(rst_b), .i_cass_out(cass_b), .i_rec_arm(arm_b),
    .i_rec_stop(stop_b), .i_ul_addr(addr_b), .i_ul_rd(rd_b), .o_ul_data(data_b),
    .o_rec_len(len_b), .o_rec_active(act_b), .o_overflow(ovf_b));

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_len;
    logic       exp_ovf;
  } vec_t;
  vec_t tbl [6];

  // decoder model state (instance B)
  localparam int M_WAIT = 0, M_CELL = 1, M_DATA = 2;
  int         m_mode, m_nb, m_len;
  logic       m_ovf;
  logic [7:0] m_acc;
  logic [7:0] m_mem [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ctl(input bit sel, input bit arm, input bit stop);
    if (sel) begin arm_b = arm; stop_b = stop; end
    else begin arm_a = arm; stop_a = stop; end
    wait_cyc(1);
    if (sel) begin arm_b = 1'b0; stop_b = 1'b0; end
    else begin arm_a = 1'b0; stop_a = 1'b0; end
  endtask

  // pulse starts d cycles after the current point, lasts one cycle
  task automatic pulse(input bit sel, input int d);
    repeat (d - 1) @(posedge clk);
    #1;
    if (sel) cass_b = 2'b01; else cass_a = 2'b01;
    wait_cyc(1);
    if (sel) cass_b = 2'b00; else cass_a = 2'b00;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] v);
    int h, f;
    h = sel ? HB : HA;
    f = sel ? FB : FA;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin pulse(sel, h); pulse(sel, h); end
      else pulse(sel, f);
    end
  endtask

  task automatic rd(input bit sel, input int a, output logic [7:0] d);
    if (sel) begin rd_b = 1'b1; addr_b = 2'(a); end
    else begin rd_a = 1'b1; addr_a = 14'(a); end
    wait_cyc(1);
    rd_a = 1'b0;
    rd_b = 1'b0;
    d = sel ? data_b : data_a;
  endtask

  task automatic model_push(input logic b);
    m_acc = {m_acc[6:0], b};
    m_nb++;
    if (m_nb == 8) begin
      m_nb = 0;
      if (m_len < 4) begin m_mem[m_len] = m_acc; m_len++; end
      else m_ovf = 1'b1;
    end
  endtask

  // apply one pulse arriving d us after the previous edge
  task automatic model_edge(input int d);
    if (m_mode != M_WAIT && d > GB) begin m_mode = M_WAIT; m_nb = 0; end
    case (m_mode)
      M_WAIT: m_mode = M_CELL;
      M_CELL: begin
        if (d <= SB) begin model_push(1'b1); m_mode = M_DATA; end
        else if (d <= LB) model_push(1'b0);
        else m_nb = 0;
      end
      M_DATA: begin
        if (d > SB) m_nb = 0;
        m_mode = M_CELL;
      end
      default: m_mode = M_WAIT;
    endcase
  endtask

  function automatic int gen_d();
    int r;
    r = int'($urandom_range(99, 0));
    if (r < 8) begin
      case ($urandom_range(5, 0))
        0: return SB;
        1: return SB + 1;
        2: return LB;
        3: return LB + 1;
        4: return GB;
        default: return GB + 1;
      endcase
    end else if (r < 48) return int'($urandom_range(SB, 2));
    else if (r < 80) return int'($urandom_range(LB, SB + 1));
    else if (r < 90) return int'($urandom_range(GB, LB + 1));
    else return int'($urandom_range(GB + 40, GB + 1));
  endfunction

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    tbl[0] = '{8'hA1, 3'd1, 1'b0};
    tbl[1] = '{8'h00, 3'd2, 1'b0};
    tbl[2] = '{8'hFF, 3'd3, 1'b0};
    tbl[3] = '{8'h3C, 3'd4, 1'b0};
    tbl[4] = '{8'h77, 3'd4, 1'b1};
    tbl[5] = '{8'hC3, 3'd4, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    cass_a = 2'b00; cass_b = 2'b00;
    arm_a = 1'b0; arm_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    rd_a = 1'b0; rd_b = 1'b0; addr_a = 14'd0; addr_b = 2'd0;
    wait_cyc(3);
    check("rst_len_a", 32'(len_a), 32'd0);
    check("rst_act_a", 32'(act_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a), 32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_len_b", 32'(len_b), 32'd0);
    check("rst_act_b", 32'(act_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    wait_cyc(1);

    fork
      begin : seq_a
        logic [7:0] da;
        // eight full cells -> 0x00
        ctl(1'b0, 1'b1, 1'b0);
        check("t1_act_armed", 32'(act_a), 32'd1);
        pulse(1'b0, 5);
        repeat (8) pulse(1'b0, FA);
        wait_cyc(3);
        check("t1_len", 32'(len_a), 32'd1);
        check("t1_act", 32'(act_a), 32'd1);
        check("t1_ovf", 32'(ovf_a), 32'd0);
        rd(1'b0, 0, da);
        check("t1_ram0", 32'(da), 32'h00);
        // 0xA5 with real timing
        ctl(1'b0, 1'b1, 1'b0);
        check("t2_len_cleared", 32'(len_a), 32'd0);
        pulse(1'b0, 5);
        send_byte(1'b0, 8'hA5);
        wait_cyc(3);
        check("t2_len", 32'(len_a), 32'd1);
        rd(1'b0, 0, da);
        check("t2_ram0", 32'(da), 32'hA5);
        addr_a = 14'd7;
        wait_cyc(2);
        check("t2_hold", 32'(data_a), 32'hA5);
        // partial byte, silence, then 0x3C
        ctl(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 5);
        pulse(1'b0, HA); pulse(1'b0, HA);
        pulse(1'b0, FA);
        pulse(1'b0, HA); pulse(1'b0, HA);
        wait_cyc(12000);
        check("t3_state_gap", 32'(dut_a.r_state), 32'(WAIT_CLK));
        check("t3_len_gap", 32'(len_a), 32'd0);
        check("t3_act_gap", 32'(act_a), 32'd1);
        pulse(1'b0, 5);
        send_byte(1'b0, 8'h3C);
        wait_cyc(3);
        check("t3_len", 32'(len_a), 32'd1);
        rd(1'b0, 0, da);
        check("t3_ram0", 32'(da), 32'h3C);
      end
      begin : seq_b
        logic [7:0] db;
        // overflow table
        ctl(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 5);
        for (int i = 0; i < 6; i++) begin
          send_byte(1'b1, tbl[i].data);
          wait_cyc(3);
          check($sformatf("t4_len_%0d", i), 32'(len_b), 32'(tbl[i].exp_len));
          check($sformatf("t4_ovf_%0d", i), 32'(ovf_b), 32'(tbl[i].exp_ovf));
        end
        for (int i = 0; i < 4; i++) begin
          rd(1'b1, i, db);
          check($sformatf("t4_ram_%0d", i), 32'(db), 32'(tbl[i].data));
        end
        ctl(1'b1, 1'b1, 1'b0);
        check("t4_rearm_len", 32'(len_b), 32'd0);
        check("t4_rearm_ovf", 32'(ovf_b), 32'd0);
        // framing error in DATA, then a clean byte
        pulse(1'b1, 5);
        pulse(1'b1, HB); pulse(1'b1, HB);
        pulse(1'b1, FB);
        pulse(1'b1, HB);
        pulse(1'b1, 20);
        wait_cyc(3);
        check("t5_state", 32'(dut_b.r_state), 32'(CELL));
        check("t5_bitcnt", 32'(dut_b.r_bit_cnt), 32'd0);
        send_byte(1'b1, 8'h96);
        wait_cyc(3);
        check("t5_len", 32'(len_b), 32'd1);
        rd(1'b1, 0, db);
        check("t5_ram0", 32'(db), 32'h96);
        ctl(1'b1, 1'b1, 1'b1);
        check("t5_stop_wins_act", 32'(act_b), 32'd0);
        check("t5_stop_wins_len", 32'(len_b), 32'd1);
        // reset mid-byte
        ctl(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 5);
        pulse(1'b1, FB); pulse(1'b1, HB); pulse(1'b1, HB); pulse(1'b1, FB);
        rst_b = 1'b1;
        #1;
        check("t6_len", 32'(len_b), 32'd0);
        check("t6_act", 32'(act_b), 32'd0);
        check("t6_ovf", 32'(ovf_b), 32'd0);
        check("t6_data", 32'(data_b), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        ctl(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 5);
        send_byte(1'b1, 8'h5A);
        wait_cyc(3);
        check("t6_len_after", 32'(len_b), 32'd1);
        rd(1'b1, 0, db);
        check("t6_ram0", 32'(db), 32'h5A);
        // randomized pulse trains vs model
        for (int r = 0; r < 8; r++) begin
          ctl(1'b1, 1'b1, 1'b0);
          m_mode = M_WAIT; m_nb = 0; m_len = 0; m_ovf = 1'b0; m_acc = 8'h00;
          for (int k = 0; k < 50; k++) begin
            int dd;
            dd = gen_d();
            pulse(1'b1, dd);
            model_edge(dd);
          end
          wait_cyc(4);
          check($sformatf("rnd%0d_len", r), 32'(len_b), 32'(m_len));
          check($sformatf("rnd%0d_ovf", r), 32'(ovf_b), 32'(m_ovf));
          check($sformatf("rnd%0d_act", r), 32'(act_b), 32'd1);
          for (int i = 0; i < m_len; i++) begin
            rd(1'b1, i, db);
            check($sformatf("rnd%0d_ram%0d", r, i), 32'(db), 32'(m_mem[i]));
          end
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
